// File: rtl/bullet_slot_arbiter.sv
// Bullet slot arbiter: edge-detects the two fire keys, enforces per-player cooldowns,
// allocates the lowest free OAM slot in the shooter's half and round-robins the write port.
module bullet_slot_arbiter #(
    parameter int unsigned SLOTS_PER_PLAYER = 8,
    parameter int unsigned COOLDOWN         = 32,
    parameter int unsigned IDX_W            = $clog2(2 * SLOTS_PER_PLAYER)
) (
    input  logic                          clk,
    input  logic                          clrn,
    input  logic                          tick,
    input  logic                          game_on,
    input  logic                          fire1,
    input  logic                          fire2,
    input  logic [9:0]                    tank1_x,
    input  logic [9:0]                    tank1_y,
    input  logic [1:0]                    tank1_dir,
    input  logic [9:0]                    tank2_x,
    input  logic [9:0]                    tank2_y,
    input  logic [1:0]                    tank2_dir,
    input  logic                          release_valid,
    input  logic [IDX_W-1:0]              release_idx,
    output logic                          grant_valid,
    output logic                          grant_player,
    output logic [IDX_W-1:0]              grant_idx,
    output logic [9:0]                    grant_x,
    output logic [9:0]                    grant_y,
    output logic [1:0]                    grant_dir,
    output logic                          drop1,
    output logic                          drop2,
    output logic [2*SLOTS_PER_PLAYER-1:0] slot_busy
);

    localparam int unsigned S    = SLOTS_PER_PLAYER;
    localparam int unsigned NS   = 2 * S;
    localparam int unsigned CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [CD_W-1:0]  CD_LOAD = CD_W'(COOLDOWN);
    localparam logic [IDX_W:0]   NS_LIM  = (IDX_W + 1)'(NS);

    typedef enum logic {PL_1 = 1'b0, PL_2 = 1'b1} player_t;

    player_t           rr;
    logic              fire_prev1, fire_prev2;
    logic              rise1_r, rise2_r;
    logic              pend1, pend2;
    logic [CD_W-1:0]   cd1, cd2;
    logic              any_free1, any_free2;
    logic [IDX_W-1:0]  free_idx1, free_idx2;
    logic              elig1, elig2, g1, g2, drop1_c, drop2_c;
    logic [NS-1:0]     busy_next;

    // Descending scan so the last hit, i.e. the lowest free index, wins.
    always_comb begin
        free_idx1 = '0;
        free_idx2 = '0;
        for (int unsigned i = S; i > 0; i--) begin
            if (!slot_busy[i-1])     free_idx1 = IDX_W'(i - 1);
            if (!slot_busy[S+i-1])   free_idx2 = IDX_W'(S + i - 1);
        end
        any_free1 = ~&slot_busy[S-1:0];
        any_free2 = ~&slot_busy[NS-1:S];
        elig1     = game_on & pend1 & any_free1;
        elig2     = game_on & pend2 & any_free2;
        drop1_c   = game_on & pend1 & ~any_free1;
        drop2_c   = game_on & pend2 & ~any_free2;
        g1        = elig1 & (~elig2 | (rr == PL_1));
        g2        = elig2 & (~elig1 | (rr == PL_2));
    end

    always_comb begin
        busy_next = slot_busy;
        if (release_valid && ({1'b0, release_idx} < NS_LIM))
            busy_next[release_idx] = 1'b0;
        if (g1) busy_next[free_idx1] = 1'b1;
        if (g2) busy_next[free_idx2] = 1'b1;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rr           <= PL_1;
            fire_prev1   <= 1'b0;
            fire_prev2   <= 1'b0;
            rise1_r      <= 1'b0;
            rise2_r      <= 1'b0;
            pend1        <= 1'b0;
            pend2        <= 1'b0;
            cd1          <= '0;
            cd2          <= '0;
            grant_valid  <= 1'b0;
            grant_player <= 1'b0;
            grant_idx    <= '0;
            grant_x      <= '0;
            grant_y      <= '0;
            grant_dir    <= '0;
            drop1        <= 1'b0;
            drop2        <= 1'b0;
            slot_busy    <= '0;
        end else begin
            fire_prev1  <= fire1;
            fire_prev2  <= fire2;
            rise1_r     <= fire1 & ~fire_prev1;
            rise2_r     <= fire2 & ~fire_prev2;
            grant_valid <= g1 | g2;
            drop1       <= drop1_c;
            drop2       <= drop2_c;
            slot_busy   <= busy_next;
            if (g1 | g2) begin
                grant_player <= g2;
                grant_idx    <= g2 ? free_idx2 : free_idx1;
                grant_x      <= g2 ? tank2_x   : tank1_x;
                grant_y      <= g2 ? tank2_y   : tank1_y;
                grant_dir    <= g2 ? tank2_dir : tank1_dir;
                rr           <= g2 ? PL_1 : PL_2;
            end
            if (!game_on) begin
                pend1 <= 1'b0;
                pend2 <= 1'b0;
                cd1   <= '0;
                cd2   <= '0;
            end else begin
                if (g1 | drop1_c)                         pend1 <= 1'b0;
                else if (rise1_r && cd1 == '0 && !pend1) pend1 <= 1'b1;
                if (g2 | drop2_c)                         pend2 <= 1'b0;
                else if (rise2_r && cd2 == '0 && !pend2) pend2 <= 1'b1;
                if (g1)                     cd1 <= CD_LOAD;
                else if (tick && cd1 != '0) cd1 <= cd1 - CD_W'(1);
                if (g2)                     cd2 <= CD_LOAD;
                else if (tick && cd2 != '0) cd2 <= cd2 - CD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bullet_slot_arbiter.sv
// Scoreboard bench for bullet_slot_arbiter: a slot/round-robin model predicts every grant
// or drop at press time; a negedge monitor pops and compares each DUT event.
module tb_bullet_slot_arbiter;

    localparam int S = 8;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       tick = 1'b0, game_on = 1'b1;
    logic       fire1 = 1'b0, fire2 = 1'b0;
    logic [9:0] tank1_x = 10'd100, tank1_y = 10'd200, tank2_x = 10'd300, tank2_y = 10'd400;
    logic [1:0] tank1_dir = 2'd1, tank2_dir = 2'd3;
    logic       release_valid = 1'b0;
    logic [3:0] release_idx = '0;
    logic       grant_valid, grant_player, drop1, drop2;
    logic [3:0] grant_idx;
    logic [9:0] grant_x, grant_y;
    logic [1:0] grant_dir;
    logic [15:0] slot_busy;

    bullet_slot_arbiter #(.SLOTS_PER_PLAYER(S), .COOLDOWN(4)) dut (
        .clk(clk), .clrn(clrn), .tick(tick), .game_on(game_on),
        .fire1(fire1), .fire2(fire2),
        .tank1_x(tank1_x), .tank1_y(tank1_y), .tank1_dir(tank1_dir),
        .tank2_x(tank2_x), .tank2_y(tank2_y), .tank2_dir(tank2_dir),
        .release_valid(release_valid), .release_idx(release_idx),
        .grant_valid(grant_valid), .grant_player(grant_player), .grant_idx(grant_idx),
        .grant_x(grant_x), .grant_y(grant_y), .grant_dir(grant_dir),
        .drop1(drop1), .drop2(drop2), .slot_busy(slot_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;    // 0 grant, 1 drop1, 2 drop2
        int player;
        int idx;
        int x;
        int y;
        int dir;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0, n_pass = 0;
    logic [15:0] busy_m = '0;
    int          rr_m = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    function automatic int lowest_free(input int p);
        for (int i = 0; i < S; i++)
            if (!busy_m[p*S+i]) return p*S + i;
        return -1;
    endfunction

    function automatic void expect_press(input int p);
        exp_t e;
        int   idx;
        idx = lowest_free(p);
        if (idx < 0) begin
            e = '{kind: p + 1, player: p, idx: 0, x: 0, y: 0, dir: 0};
        end else begin
            busy_m[idx] = 1'b1;
            e = '{kind: 0, player: p, idx: idx,
                  x:   (p == 0) ? int'(tank1_x) : int'(tank2_x),
                  y:   (p == 0) ? int'(tank1_y) : int'(tank2_y),
                  dir: (p == 0) ? int'(tank1_dir) : int'(tank2_dir)};
            rr_m = 1 - p;
        end
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (clrn) begin
            if (grant_valid) begin
                if (sb.size() == 0) check("unexpected_grant", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("ev_kind", 0, e.kind);
                    check("g_player", int'(grant_player), e.player);
                    check("g_idx", int'(grant_idx), e.idx);
                    check("g_x", int'(grant_x), e.x);
                    check("g_y", int'(grant_y), e.y);
                    check("g_dir", int'(grant_dir), e.dir);
                end
            end
            if (drop1) begin
                if (sb.size() == 0) check("unexpected_drop1", 1, 0);
                else begin e = sb.pop_front(); check("ev_kind", 1, e.kind); end
            end
            if (drop2) begin
                if (sb.size() == 0) check("unexpected_drop2", 1, 0);
                else begin e = sb.pop_front(); check("ev_kind", 2, e.kind); end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1; step();
            tick = 1'b0; step();
        end
    endtask

    task automatic press(input bit p1, input bit p2);
        fire1 = p1; fire2 = p2;
        step();
        fire1 = 1'b0; fire2 = 1'b0;
        step();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30 && sb.size() != 0; i++) step();
        check("scoreboard_drained", sb.size(), 0);
        repeat (4) step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, int'(grant_valid), 0);
        check({tag, "_player"}, int'(grant_player), 0);
        check({tag, "_idx"}, int'(grant_idx), 0);
        check({tag, "_xy"}, int'({grant_x, grant_y, grant_dir}), 0);
        check({tag, "_drops"}, int'({drop1, drop2}), 0);
        check({tag, "_busy"}, int'(slot_busy), 0);
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        step();
        check_all_zero("reset");
        sb.delete();
        busy_m = '0;
        rr_m   = 0;
        clrn   = 1'b1;
        step();
    endtask

    initial begin
        do_reset();

        // 1: single press, latency and sampled position
        expect_press(0);
        fire1 = 1'b1;
        step();
        step();
        check("lat_t1_no_grant", int'(grant_valid), 0);
        step();
        check("lat_t2_grant", int'(grant_valid), 1);
        fire1 = 1'b0;
        wait_idle();

        // 4: second press inside cooldown ignored, after expiry granted idx 1
        ticks(2);
        press(1, 0);
        wait_idle();
        ticks(2);
        expect_press(0);
        press(1, 0);
        wait_idle();
        check("cd_busy", int'(slot_busy), 16'h0003);

        // 2: simultaneous rise after reset
        do_reset();
        expect_press(0);
        expect_press(1);
        press(1, 1);
        wait_idle();
        check("both_busy", int'(slot_busy), 16'h0101);

        // 5: contention fairness, including after a lone P1 grant
        for (int k = 0; k < 3; k++) begin
            ticks(4);
            if (rr_m == 0) begin expect_press(0); expect_press(1); end
            else begin expect_press(1); expect_press(0); end
            press(1, 1);
            wait_idle();
        end
        ticks(4);
        expect_press(0);
        press(1, 0);
        wait_idle();
        ticks(4);
        expect_press(1);
        expect_press(0);
        press(1, 1);
        wait_idle();

        // game_on low: press ignored, occupancy kept
        game_on = 1'b0;
        press(1, 1);
        wait_idle();
        check("gameoff_busy", int'(slot_busy), int'(busy_m));
        game_on = 1'b1;

        // 3: fill P1 half, overflow drop, release then reuse
        do_reset();
        for (int k = 0; k < 9; k++) begin
            tank1_x = 10'(100 + k);
            expect_press(0);
            press(1, 0);
            wait_idle();
            ticks(4);
        end
        check("full_busy", int'(slot_busy), 16'h00FF);
        release_idx = 4'd3; release_valid = 1'b1;
        step();
        release_valid = 1'b0;
        check("release_busy", int'(slot_busy), 16'h00F7);
        busy_m[3] = 1'b0;
        expect_press(0);
        press(1, 0);
        wait_idle();
        check("refill_busy", int'(slot_busy), 16'h00FF);

        // 6: reset while pend1 set and half full, fire held through deassertion
        ticks(4);
        fire1 = 1'b1;
        step();
        step();
        #1 clrn = 1'b0;
        #1 check_all_zero("midreset");
        sb.delete();
        step();
        busy_m = '0;
        rr_m   = 0;
        clrn   = 1'b1;
        expect_press(0);
        step();
        wait_idle();
        fire1 = 1'b0;
        check("post_reset_busy", int'(slot_busy), 16'h0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
